alu_arbiter: RTL

Round-robin arbiter and sequencer that shares one bit32_alu instance between two requesters over valid/ready handshakes. It registers the winning operands and opcode, runs one ALU evaluation, and holds the registered result and flags on a single response channel tagged with the requester id. It screens illegal opcodes and counts completed operations. It sits between the two issue ports of the datapath and the shared 32-bit ALU.

---
 rtl/alu_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one 32-bit ALU between two valid/ready requesters.
// One registered response channel carries the result, flags and the issuing requester id.

module bit32_alu (
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_r,
    output logic        o_z,
    output logic        o_v,
    output logic        o_c
);
    logic        w_sub;
    logic [31:0] w_bx;
    logic [32:0] w_sum;

    // Subtraction is a + ~b + 1, so CarryOut means "no borrow" for SUB/SUBU.
    assign w_sub = (i_op == 4'b0110) || (i_op == 4'b1110);
    assign w_bx  = i_b ^ {32{w_sub}};
    assign w_sum = {1'b0, i_a} + {1'b0, w_bx} + {32'd0, w_sub};

    always_comb begin
        o_r = '0;
        o_v = 1'b0;
        o_c = 1'b0;
        case (i_op)
            4'b0000: o_r = i_a & i_b;
            4'b0001: o_r = i_a | i_b;
            4'b0101: o_r = ~(i_a | i_b);
            4'b0010, 4'b0110: begin
                o_r = w_sum[31:0];
                o_c = w_sum[32];
                o_v = (i_a[31] == w_bx[31]) && (w_sum[31] != i_a[31]);
            end
            4'b1010, 4'b1110: begin
                o_r = w_sum[31:0];
                o_c = w_sum[32];
            end
            4'b0111: o_r = {31'd0, $signed(i_a) < $signed(i_b)};
            4'b1111: o_r = {31'd0, i_a < i_b};
            4'b1000: o_r = i_a << i_b[4:0];
            4'b1001: o_r = i_a >> i_b[4:0];
            default: o_r = '0;
        endcase
    end

    assign o_z = (o_r == 32'd0);
endmodule

module alu_arbiter #(
    parameter int CNT_W    = 16,
    parameter bit CHECK_OP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [31:0]      resp_r,
    output logic             resp_z,
    output logic             resp_v,
    output logic             resp_c,
    output logic             resp_err,
    output logic [CNT_W-1:0] op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      r_state, w_next;
    logic        r_last;
    logic        r_id;
    logic [3:0]  r_op;
    logic [31:0] r_a, r_b;

    logic        w_any, w_gnt, w_hs, w_illegal;
    logic [31:0] w_alu_r;
    logic        w_alu_z, w_alu_v, w_alu_c;

    // Contention goes to whoever did not win last; a lone requester always wins.
    assign w_any = req0_valid | req1_valid;
    assign w_gnt = (req0_valid & req1_valid) ? ~r_last : req1_valid;
    assign w_hs  = (r_state == IDLE) && w_any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (r_state)
            IDLE: if (w_any) begin
                req0_ready = ~w_gnt;
                req1_ready = w_gnt;
                w_next     = EXEC;
            end
            EXEC:    w_next = RESP;
            RESP:    if (resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        case (r_op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1010, 4'b1110,
            4'b0101, 4'b0111, 4'b1111, 4'b1000, 4'b1001: w_illegal = 1'b0;
            default:                                       w_illegal = CHECK_OP;
        endcase
    end

    bit32_alu u_alu (
        .i_op (r_op),
        .i_a  (r_a),
        .i_b  (r_b),
        .o_r  (w_alu_r),
        .o_z  (w_alu_z),
        .o_v  (w_alu_v),
        .o_c  (w_alu_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last     <= 1'b1;
            r_id       <= 1'b0;
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_r     <= '0;
            resp_z     <= 1'b0;
            resp_v     <= 1'b0;
            resp_c     <= 1'b0;
            resp_err   <= 1'b0;
            op_count   <= '0;
        end else begin
            if (w_hs) begin
                r_id   <= w_gnt;
                r_last <= w_gnt;
                r_op   <= w_gnt ? req1_op : req0_op;
                r_a    <= w_gnt ? req1_a  : req0_a;
                r_b    <= w_gnt ? req1_b  : req0_b;
            end
            if (r_state == EXEC) begin
                resp_valid <= 1'b1;
                resp_id    <= r_id;
                resp_err   <= w_illegal;
                resp_r     <= w_illegal ? 32'd0 : w_alu_r;
                resp_z     <= w_illegal ? 1'b0  : w_alu_z;
                resp_v     <= w_illegal ? 1'b0  : w_alu_v;
                resp_c     <= w_illegal ? 1'b0  : w_alu_c;
            end
            if ((r_state == RESP) && resp_ready) begin
                resp_valid <= 1'b0;
                op_count   <= op_count + 1'b1;
            end
        end
    end
endmodule
